// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SYNC/CMD/ADDR/DATA/CHK frames into register
// bus accesses and returns a 4-byte SYNC/STATUS/ADDR/DATA response frame.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] from_uart_data,
  input  logic       from_uart_valid,
  input  logic       from_uart_error,
  output logic       from_uart_ready,
  output logic [7:0] to_uart_data,
  output logic       to_uart_valid,
  output logic       to_uart_error,
  input  logic       to_uart_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_write,
  output logic       reg_read,
  input  logic [7:0] reg_rdata
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CHK  = 8'h01;
  localparam logic [7:0] ST_BAD_CMD  = 8'h02;

  typedef enum logic [2:0] {
    HUNT, RX_CMD, RX_ADDR, RX_DATA, RX_CHK, EXEC, RD_WAIT, TX
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    resp_q, resp_d;
  logic          is_read_q, is_read_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    reg_addr_q, reg_addr_d;
  logic [7:0]    reg_wdata_q, reg_wdata_d;
  logic          reg_write_q, reg_write_d;
  logic          reg_read_q, reg_read_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          ready_q, ready_d;

  logic       accept_c;
  logic [7:0] sum_c;
  logic [1:0] nxt_idx_c;

  assign accept_c = from_uart_valid & ready_q;
  assign sum_c    = cmd_q + addr_q + data_q;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    timer_d     = timer_q;
    status_d    = status_q;
    resp_d      = resp_q;
    is_read_d   = is_read_q;
    idx_d       = idx_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    nxt_idx_c   = idx_q + 2'd1;

    case (state_q)
      HUNT: begin
        timer_d = '0;
        if (accept_c && !from_uart_error && from_uart_data == SYNC_BYTE) begin
          state_d = RX_CMD;
        end
      end

      RX_CMD, RX_ADDR, RX_DATA, RX_CHK: begin
        if (accept_c) begin
          timer_d = '0;
          if (from_uart_error) begin
            state_d = HUNT;
          end else begin
            case (state_q)
              RX_CMD:  begin cmd_d  = from_uart_data; state_d = RX_ADDR; end
              RX_ADDR: begin addr_d = from_uart_data; state_d = RX_DATA; end
              RX_DATA: begin data_d = from_uart_data; state_d = RX_CHK;  end
              default: begin
                // Frame verdict is resolved here so the strobe lands in EXEC.
                state_d     = EXEC;
                reg_addr_d  = addr_q;
                reg_wdata_d = data_q;
                resp_d      = data_q;
                is_read_d   = 1'b0;
                if (from_uart_data != sum_c) begin
                  status_d = ST_BAD_CHK;
                end else if (cmd_q == CMD_WRITE) begin
                  status_d    = ST_OK;
                  reg_write_d = 1'b1;
                end else if (cmd_q == CMD_READ) begin
                  status_d   = ST_OK;
                  reg_read_d = 1'b1;
                  is_read_d  = 1'b1;
                end else begin
                  status_d = ST_BAD_CMD;
                end
              end
            endcase
          end
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = HUNT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      EXEC: begin
        if (is_read_q) begin
          state_d = RD_WAIT;
        end else begin
          state_d    = TX;
          idx_d      = 2'd0;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
        end
      end

      RD_WAIT: begin
        resp_d     = reg_rdata;
        status_d   = ST_OK;
        state_d    = TX;
        idx_d      = 2'd0;
        tx_data_d  = SYNC_BYTE;
        tx_valid_d = 1'b1;
      end

      TX: begin
        if (tx_valid_q && to_uart_ready) begin
          if (idx_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = HUNT;
          end else begin
            idx_d = nxt_idx_c;
            case (nxt_idx_c)
              2'd1:    tx_data_d = status_q;
              2'd2:    tx_data_d = reg_addr_q;
              default: tx_data_d = resp_q;
            endcase
          end
        end
      end

      default: state_d = HUNT;
    endcase

    ready_d = (state_d == HUNT) || (state_d == RX_CMD) || (state_d == RX_ADDR) ||
              (state_d == RX_DATA) || (state_d == RX_CHK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      status_q    <= '0;
      resp_q      <= '0;
      is_read_q   <= 1'b0;
      idx_q       <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      status_q    <= status_d;
      resp_q      <= resp_d;
      is_read_q   <= is_read_d;
      idx_q       <= idx_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign from_uart_ready = ready_q;
  assign to_uart_data    = tx_data_q;
  assign to_uart_valid   = tx_valid_q;
  assign to_uart_error   = 1'b0;
  assign reg_addr        = reg_addr_q;
  assign reg_wdata       = reg_wdata_q;
  assign reg_write       = reg_write_q;
  assign reg_read        = reg_read_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed and random frames checked against a
// frame-level model with its own register image.
module tb_uart_cmd_ctrl;

  localparam int unsigned TMO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] from_uart_data = '0;
  logic       from_uart_valid = 1'b0;
  logic       from_uart_error = 1'b0;
  logic       from_uart_ready;
  logic [7:0] to_uart_data;
  logic       to_uart_valid;
  logic       to_uart_error;
  logic       to_uart_ready = 1'b1;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_rdata = '0;

  uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .from_uart_data(from_uart_data), .from_uart_valid(from_uart_valid),
    .from_uart_error(from_uart_error), .from_uart_ready(from_uart_ready),
    .to_uart_data(to_uart_data), .to_uart_valid(to_uart_valid),
    .to_uart_error(to_uart_error), .to_uart_ready(to_uart_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .reg_read(reg_read), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register slave and the model's own image of it
  logic [7:0] slave_mem [256];
  logic [7:0] model_mem [256];
  always @(posedge clk) begin
    if (reg_read)  reg_rdata <= slave_mem[reg_addr];
    if (reg_write) slave_mem[reg_addr] <= reg_wdata;
  end

  // Transmit-ready pattern: 0 always ready, 1 random, 2 five stall cycles per byte
  int rmode = 0;
  int stall = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: to_uart_ready = 1'b1;
      1: to_uart_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!to_uart_valid) begin
          stall = 0; to_uart_ready = 1'b0;
        end else if (stall >= 5) begin
          stall = 0; to_uart_ready = 1'b1;
        end else begin
          stall++; to_uart_ready = 1'b0;
        end
      end
    endcase
  end

  // Observation monitor, sampled mid-cycle
  logic [7:0]  tx_q [$];
  int          n_wr, n_rd, stab_viol, rdy_viol;
  int unsigned last_acc, wr_cyc, rd_cyc, first_cyc;
  logic [7:0]  wr_addr, wr_data, rd_addr, hold_data;
  bit          seen_first, hold_pending;

  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (from_uart_valid && from_uart_ready) last_acc = cyc;
      if (reg_write) begin n_wr++; wr_cyc = cyc; wr_addr = reg_addr; wr_data = reg_wdata; end
      if (reg_read)  begin n_rd++; rd_cyc = cyc; rd_addr = reg_addr; end
      if (to_uart_valid && !seen_first) begin seen_first = 1'b1; first_cyc = cyc; end
      if (hold_pending && (!to_uart_valid || to_uart_data != hold_data)) stab_viol++;
      hold_pending = to_uart_valid && !to_uart_ready;
      hold_data    = to_uart_data;
      if (to_uart_valid && to_uart_ready) tx_q.push_back(to_uart_data);
      if (to_uart_valid && from_uart_ready) rdy_viol++;
    end
  end

  task automatic clear_obs();
    tx_q.delete();
    n_wr = 0; n_rd = 0; stab_viol = 0; rdy_viol = 0; seen_first = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n;
    n = 0;
    while (from_uart_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (from_uart_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: from_uart_ready=%b required 1", from_uart_ready);
    end
    from_uart_data = b; from_uart_error = e; from_uart_valid = 1'b1;
    @(posedge clk); #1;
    from_uart_valid = 1'b0; from_uart_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send one frame and check the full transaction against the model
  task automatic run_frame(input string nm, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] k);
    logic [7:0] sum, st, last;
    logic [7:0] exp_b [4];
    int kind, n;
    sum = c + a + d;
    if (k != sum)          begin st = 8'h01; kind = 0; last = d; end
    else if (c == 8'h01)   begin st = 8'h00; kind = 1; last = d; model_mem[a] = d; end
    else if (c == 8'h02)   begin st = 8'h00; kind = 2; last = model_mem[a]; end
    else                   begin st = 8'h02; kind = 0; last = d; end
    exp_b[0] = 8'hA5; exp_b[1] = st; exp_b[2] = a; exp_b[3] = last;

    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(c, 1'b0); send_byte(a, 1'b0);
    send_byte(d, 1'b0);     send_byte(k, 1'b0);
    n = 0;
    while (tx_q.size() < 4 && n < 400) begin @(posedge clk); #1; n++; end
    idle(3);

    checks++;
    if (tx_q.size() != 4) begin
      errors++;
      $display("FAIL %s tx_count: got %0d bytes, required 4", nm, tx_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= tx_q.size()) begin
        errors++;
        $display("FAIL %s tx_byte%0d: missing, required %h", nm, i, exp_b[i]);
      end else if (tx_q[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s tx_byte%0d: got %h required %h", nm, i, tx_q[i], exp_b[i]);
      end
    end
    checks++;
    if (n_wr != (kind == 1 ? 1 : 0) || n_rd != (kind == 2 ? 1 : 0)) begin
      errors++;
      $display("FAIL %s strobes: writes=%0d reads=%0d required kind %0d", nm, n_wr, n_rd, kind);
    end
    if (kind == 1) begin
      checks++;
      if (wr_addr !== a || wr_data !== d || wr_cyc != last_acc + 1) begin
        errors++;
        $display("FAIL %s write: addr=%h data=%h lat=%0d required %h %h 1",
                 nm, wr_addr, wr_data, wr_cyc - last_acc, a, d);
      end
    end
    if (kind == 2) begin
      checks++;
      if (rd_addr !== a || rd_cyc != last_acc + 1) begin
        errors++;
        $display("FAIL %s read: addr=%h lat=%0d required %h 1", nm, rd_addr, rd_cyc - last_acc, a);
      end
    end
    checks++;
    if (!seen_first || first_cyc != last_acc + (kind == 2 ? 3 : 2)) begin
      errors++;
      $display("FAIL %s tx_latency: got %0d required %0d", nm, first_cyc - last_acc,
               (kind == 2 ? 3 : 2));
    end
    checks++;
    if (stab_viol != 0 || rdy_viol != 0) begin
      errors++;
      $display("FAIL %s tx_hold: stability=%0d rx_ready_in_tx=%0d required 0 0",
               nm, stab_viol, rdy_viol);
    end
  endtask

  task automatic check_silent(input string nm);
    idle(20);
    checks++;
    if (tx_q.size() != 0 || n_wr != 0 || n_rd != 0) begin
      errors++;
      $display("FAIL %s silent: tx=%0d writes=%0d reads=%0d required 0 0 0",
               nm, tx_q.size(), n_wr, n_rd);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (from_uart_ready !== 1'b1 || to_uart_valid !== 1'b0 || to_uart_data !== 8'h00 ||
        to_uart_error !== 1'b0 || reg_write !== 1'b0 || reg_read !== 1'b0 ||
        reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
      errors++;
      $display("FAIL %s reset_state: rdy=%b tv=%b td=%h te=%b w=%b r=%b a=%h wd=%h required 1 0 00 0 0 0 00 00",
               nm, from_uart_ready, to_uart_valid, to_uart_data, to_uart_error,
               reg_write, reg_read, reg_addr, reg_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    check_reset_outputs("test_reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_frame("write", 8'h01, 8'h10, 8'h3C, 8'h4D);
  endtask

  task automatic test_read();
    slave_mem[8'h22] = 8'h5A; model_mem[8'h22] = 8'h5A;
    run_frame("read", 8'h02, 8'h22, 8'h00, 8'h24);
  endtask

  task automatic test_bad_frames();
    run_frame("bad_chk", 8'h01, 8'h10, 8'h3C, 8'h00);
    run_frame("bad_cmd", 8'h07, 8'h10, 8'h3C, 8'h53);
  endtask

  task automatic test_abort_error();
    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b1);
    check_silent("abort_err");
    run_frame("after_err", 8'h01, 8'h10, 8'h3C, 8'h4D);
    clear_obs();
    send_byte(8'hA5, 1'b1);
    run_frame("hunt_err", 8'h01, 8'h11, 8'h77, 8'h89);
  endtask

  task automatic test_timeout();
    int n;
    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
    idle(TMO + 1);
    check_silent("timeout");
    run_frame("after_tmo", 8'h01, 8'h10, 8'h3C, 8'h4D);
    // A gap just under the limit must not abort
    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h12, 1'b0);
    idle(TMO - 2);
    send_byte(8'h66, 1'b0); send_byte(8'h79, 1'b0);
    model_mem[8'h12] = 8'h66;
    n = 0;
    while (tx_q.size() < 4 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (tx_q.size() != 4 || n_wr != 1 || tx_q[tx_q.size() - 1] !== 8'h66) begin
      errors++;
      $display("FAIL slow_gap: tx=%0d writes=%0d required 4 1", tx_q.size(), n_wr);
    end
  endtask

  task automatic test_backpressure();
    rmode = 2;
    run_frame("bp_write", 8'h01, 8'h40, 8'hC3, 8'h04);
    run_frame("bp_read",  8'h02, 8'h40, 8'h99, 8'hDB);
    rmode = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_frame");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_frame("after_rst_rx", 8'h01, 8'h21, 8'h05, 8'h27);

    rmode = 2;
    clear_obs();
    send_byte(8'hA5, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h21, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h23, 1'b0);
    n = 0;
    while (tx_q.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (to_uart_valid !== 1'b1 || tx_q.size() != 2) begin
      errors++;
      $display("FAIL reset_mid_tx setup: valid=%b bytes=%0d required 1 2", to_uart_valid, tx_q.size());
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid_tx");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_frame("after_rst_tx", 8'h01, 8'h21, 8'hE0, 8'h02);
    rmode = 0;
  endtask

  task automatic test_random();
    logic [7:0] c, a, d, k;
    int r;
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      k = c + a + d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      run_frame("random", c, a, d, k);
    end
    rmode = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      model_mem[i] = slave_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_bad_frames();
    test_abort_error();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
